// File: rtl/mem_access_unit_if.sv
// Execute-side, writeback-side and SRAM-like data-bus signals of the MEM-stage access unit.
// Handshakes: a transfer happens on a rising edge where valid and ready are both high; data_req/data_addr_ok and data_data_ok follow the same rule.
interface mem_access_unit_if;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_result;
   logic [31:0] in_wdata;
   logic [2:0]  in_load_op;
   logic [1:0]  in_store_op;
   logic        in_except;
   logic [4:0]  in_dst;
   logic        flush;
   logic        data_req;
   logic        data_wr;
   logic [1:0]  data_size;
   logic [31:0] data_addr;
   logic [3:0]  data_wstrb;
   logic [31:0] data_wdata;
   logic        data_addr_ok;
   logic        data_data_ok;
   logic [31:0] data_rdata;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_result;
   logic [4:0]  out_dst;
   logic        mem_stall;

   modport master (
      output in_valid, in_result, in_wdata, in_load_op, in_store_op, in_except, in_dst,
      output flush, data_addr_ok, data_data_ok, data_rdata, out_ready,
      input  in_ready, data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
      input  out_valid, out_result, out_dst, mem_stall
   );

   modport slave (
      input  in_valid, in_result, in_wdata, in_load_op, in_store_op, in_except, in_dst,
      input  flush, data_addr_ok, data_data_ok, data_rdata, out_ready,
      output in_ready, data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
      output out_valid, out_result, out_dst, mem_stall
   );
endinterface

// File: rtl/mem_access_unit.sv
// Single-entry MEM stage: issues loads/stores on a split request/response bus, aligns load data,
// and drains an outstanding response after a flush. All bus and out_* outputs are registered.
module mem_access_unit (
   input  logic              clk,
   input  logic              resetn,
   mem_access_unit_if.slave  bus,
   output logic [2:0]        dbg_state
);
   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      REQ   = 3'd1,
      WAIT  = 3'd2,
      DONE  = 3'd3,
      DRAIN = 3'd4
   } state_t;

   state_t      state;
   logic [31:0] result_q;
   logic [2:0]  load_op_q;
   logic        is_load_q;

   logic        accept;
   logic        acc_is_load;
   logic        acc_is_mem;
   logic [1:0]  acc_size;
   logic [3:0]  acc_wstrb;
   logic [31:0] acc_wdata;
   logic [1:0]  acc_a;

   assign bus.in_ready  = !bus.flush && ((state == IDLE) || ((state == DONE) && bus.out_ready));
   assign bus.mem_stall = bus.in_valid && !bus.in_ready;
   assign accept        = bus.in_valid && bus.in_ready;
   assign dbg_state     = state;
   assign acc_a         = bus.in_result[1:0];

   // Request fields decoded from the incoming instruction; a load wins over a simultaneous store.
   always_comb begin
      acc_is_load = (bus.in_load_op >= 3'd1) && (bus.in_load_op <= 3'd5);
      acc_is_mem  = (acc_is_load || (bus.in_store_op != 2'd0)) && !bus.in_except;
      acc_size    = 2'd2;
      acc_wstrb   = 4'b0000;
      acc_wdata   = 32'd0;
      if (acc_is_load) begin
         case (bus.in_load_op)
            3'd1, 3'd2: acc_size = 2'd0;
            3'd3, 3'd4: acc_size = 2'd1;
            default:    acc_size = 2'd2;
         endcase
      end else begin
         case (bus.in_store_op)
            2'd1: begin
               acc_size  = 2'd0;
               acc_wstrb = 4'b0001 << acc_a;
               acc_wdata = {4{bus.in_wdata[7:0]}};
            end
            2'd2: begin
               acc_size  = 2'd1;
               acc_wstrb = acc_a[1] ? 4'b1100 : 4'b0011;
               acc_wdata = {2{bus.in_wdata[15:0]}};
            end
            default: begin
               acc_size  = 2'd2;
               acc_wstrb = 4'b1111;
               acc_wdata = bus.in_wdata;
            end
         endcase
      end
   end

   function automatic logic [31:0] align_load(input logic [2:0] op, input logic [1:0] a,
                                              input logic [31:0] rdata);
      logic [31:0] shifted;
      logic [7:0]  b;
      logic [15:0] h;
      shifted = rdata >> {a, 3'b000};
      b = shifted[7:0];
      h = a[1] ? rdata[31:16] : rdata[15:0];
      case (op)
         3'd1:    align_load = {{24{b[7]}}, b};
         3'd2:    align_load = {24'd0, b};
         3'd3:    align_load = {{16{h[15]}}, h};
         3'd4:    align_load = {16'd0, h};
         default: align_load = rdata;
      endcase
   endfunction

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state          <= IDLE;
         result_q       <= 32'd0;
         load_op_q      <= 3'd0;
         is_load_q      <= 1'b0;
         bus.data_req   <= 1'b0;
         bus.data_wr    <= 1'b0;
         bus.data_size  <= 2'd0;
         bus.data_addr  <= 32'd0;
         bus.data_wstrb <= 4'd0;
         bus.data_wdata <= 32'd0;
         bus.out_valid  <= 1'b0;
         bus.out_result <= 32'd0;
         bus.out_dst    <= 5'd0;
      end else if (accept) begin
         result_q    <= bus.in_result;
         load_op_q   <= bus.in_load_op;
         is_load_q   <= acc_is_load;
         bus.out_dst <= bus.in_dst;
         if (acc_is_mem) begin
            state          <= REQ;
            bus.data_req   <= 1'b1;
            bus.data_wr    <= !acc_is_load;
            bus.data_size  <= acc_size;
            bus.data_addr  <= bus.in_result;
            bus.data_wstrb <= acc_wstrb;
            bus.data_wdata <= acc_wdata;
            bus.out_valid  <= 1'b0;
         end else begin
            state          <= DONE;
            bus.out_valid  <= 1'b1;
            bus.out_result <= bus.in_result;
         end
      end else begin
         case (state)
            IDLE: state <= IDLE;
            REQ: begin
               if (bus.data_addr_ok) begin
                  bus.data_req <= 1'b0;
                  state        <= bus.flush ? DRAIN : WAIT;
               end else if (bus.flush) begin
                  bus.data_req <= 1'b0;
                  state        <= IDLE;
               end
            end
            WAIT: begin
               if (bus.flush) begin
                  state <= bus.data_data_ok ? IDLE : DRAIN;
               end else if (bus.data_data_ok) begin
                  state          <= DONE;
                  bus.out_valid  <= 1'b1;
                  bus.out_result <= is_load_q ? align_load(load_op_q, result_q[1:0], bus.data_rdata)
                                              : result_q;
               end
            end
            DONE: begin
               if (bus.flush || bus.out_ready) begin
                  state         <= IDLE;
                  bus.out_valid <= 1'b0;
               end
            end
            DRAIN: if (bus.data_data_ok) state <= IDLE;
            default: begin
               state         <= IDLE;
               bus.data_req  <= 1'b0;
               bus.out_valid <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: each task drives one scenario and checks hand-computed values.
module tb_mem_access_unit;
   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_REQ   = 3'd1;
   localparam logic [2:0] S_DRAIN = 3'd4;

   logic       clk;
   logic       resetn;
   logic [2:0] dbg_state;
   int         pass_cnt;
   int         total_cnt;

   mem_access_unit_if bus ();

   mem_access_unit dut (
      .clk       (clk),
      .resetn    (resetn),
      .bus       (bus.slave),
      .dbg_state (dbg_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      bus.in_valid     = 1'b0;
      bus.in_result    = 32'd0;
      bus.in_wdata     = 32'd0;
      bus.in_load_op   = 3'd0;
      bus.in_store_op  = 2'd0;
      bus.in_except    = 1'b0;
      bus.in_dst       = 5'd0;
      bus.flush        = 1'b0;
      bus.data_addr_ok = 1'b0;
      bus.data_data_ok = 1'b0;
      bus.data_rdata   = 32'd0;
   endtask

   task automatic present(input logic [31:0] res, input logic [31:0] wd, input logic [2:0] lop,
                          input logic [1:0] sop, input logic exc, input logic [4:0] dst);
      bus.in_valid    = 1'b1;
      bus.in_result   = res;
      bus.in_wdata    = wd;
      bus.in_load_op  = lop;
      bus.in_store_op = sop;
      bus.in_except   = exc;
      bus.in_dst      = dst;
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      clear_inputs();
      bus.out_ready = 1'b1;
      #12;
      total_cnt++; if (dbg_state !== S_IDLE) $display("FAIL reset_state: got %0d want %0d", dbg_state, S_IDLE); else pass_cnt++;
      total_cnt++; if (bus.data_req !== 1'b0) $display("FAIL reset_data_req: got %b want 0", bus.data_req); else pass_cnt++;
      total_cnt++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); else pass_cnt++;
      total_cnt++; if ({bus.data_wstrb, bus.data_wdata, bus.out_result} !== 68'd0) $display("FAIL reset_regs: got %h want 0", {bus.data_wstrb, bus.data_wdata, bus.out_result}); else pass_cnt++;
      total_cnt++; if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); else pass_cnt++;
      total_cnt++; if (bus.mem_stall !== 1'b0) $display("FAIL reset_mem_stall: got %b want 0", bus.mem_stall); else pass_cnt++;
      @(posedge clk);
      #1 resetn = 1'b1;
      tick();
   endtask

   task automatic test_back_to_back();
      logic [31:0] vals [3];
      vals[0] = 32'h11; vals[1] = 32'h22; vals[2] = 32'h33;
      bus.out_ready = 1'b1;
      present(vals[0], 32'd0, 3'd0, 2'd0, 1'b0, 5'd1);
      for (int i = 0; i < 3; i++) begin
         total_cnt++; if (bus.mem_stall !== 1'b0) $display("FAIL b2b_stall%0d: got %b want 0", i, bus.mem_stall); else pass_cnt++;
         tick();
         if (i < 2) present(vals[i+1], 32'd0, 3'd0, 2'd0, 1'b0, 5'(i + 2));
         else bus.in_valid = 1'b0;
         total_cnt++; if (bus.out_valid !== 1'b1 || bus.out_result !== vals[i]) $display("FAIL b2b_out%0d: got v=%b %h want v=1 %h", i, bus.out_valid, bus.out_result, vals[i]); else pass_cnt++;
      end
      tick();
      total_cnt++; if (bus.out_valid !== 1'b0) $display("FAIL b2b_end: got %b want 0", bus.out_valid); else pass_cnt++;
   endtask

   task automatic test_load(input string name, input logic [2:0] lop, input logic [31:0] addr,
                            input logic [31:0] rdata, input logic [1:0] exp_size,
                            input logic [31:0] exp);
      bus.out_ready = 1'b1;
      present(addr, 32'hFFFF_FFFF, lop, 2'd0, 1'b0, 5'd9);
      tick();
      clear_inputs();
      total_cnt++; if (bus.data_req !== 1'b1 || bus.data_wr !== 1'b0 || bus.data_addr !== addr) $display("FAIL %s_req: got req=%b wr=%b addr=%h want 1 0 %h", name, bus.data_req, bus.data_wr, bus.data_addr, addr); else pass_cnt++;
      total_cnt++; if (bus.data_size !== exp_size || bus.data_wstrb !== 4'd0) $display("FAIL %s_size: got size=%0d strb=%b want %0d 0000", name, bus.data_size, bus.data_wstrb, exp_size); else pass_cnt++;
      bus.data_addr_ok = 1'b1;
      tick();
      bus.data_addr_ok = 1'b0;
      total_cnt++; if (bus.data_req !== 1'b0 || bus.out_valid !== 1'b0) $display("FAIL %s_wait: got req=%b v=%b want 0 0", name, bus.data_req, bus.out_valid); else pass_cnt++;
      bus.data_data_ok = 1'b1;
      bus.data_rdata   = rdata;
      tick();
      bus.data_data_ok = 1'b0;
      total_cnt++; if (bus.out_valid !== 1'b1 || bus.out_result !== exp || bus.out_dst !== 5'd9) $display("FAIL %s_result: got v=%b %h dst=%0d want v=1 %h dst=9", name, bus.out_valid, bus.out_result, bus.out_dst, exp); else pass_cnt++;
      tick();
   endtask

   task automatic test_store(input string name, input logic [1:0] sop, input logic [31:0] addr,
                             input logic [31:0] wd, input logic [31:0] exp_wdata,
                             input logic [3:0] exp_strb, input logic [1:0] exp_size);
      bus.out_ready = 1'b1;
      present(addr, wd, 3'd0, sop, 1'b0, 5'd3);
      tick();
      present(32'h55, 32'd0, 3'd0, 2'd0, 1'b0, 5'd4);
      for (int c = 0; c < 2; c++) begin
         total_cnt++; if (bus.data_req !== 1'b1 || bus.data_wr !== 1'b1 || bus.data_wstrb !== exp_strb || bus.data_wdata !== exp_wdata || bus.data_size !== exp_size || bus.data_addr !== addr) $display("FAIL %s_req%0d: got req=%b wr=%b strb=%b wdata=%h size=%0d addr=%h want 1 1 %b %h %0d %h", name, c, bus.data_req, bus.data_wr, bus.data_wstrb, bus.data_wdata, bus.data_size, bus.data_addr, exp_strb, exp_wdata, exp_size, addr); else pass_cnt++;
         total_cnt++; if (bus.mem_stall !== 1'b1) $display("FAIL %s_stall_req%0d: got %b want 1", name, c, bus.mem_stall); else pass_cnt++;
         if (c == 1) bus.data_addr_ok = 1'b1;
         tick();
      end
      bus.data_addr_ok = 1'b0;
      total_cnt++; if (bus.mem_stall !== 1'b1 || bus.data_req !== 1'b0) $display("FAIL %s_stall_wait: got stall=%b req=%b want 1 0", name, bus.mem_stall, bus.data_req); else pass_cnt++;
      bus.data_data_ok = 1'b1;
      tick();
      bus.data_data_ok = 1'b0;
      total_cnt++; if (bus.out_valid !== 1'b1 || bus.out_result !== addr || bus.mem_stall !== 1'b0) $display("FAIL %s_done: got v=%b %h stall=%b want v=1 %h stall=0", name, bus.out_valid, bus.out_result, bus.mem_stall, addr); else pass_cnt++;
      tick();
      clear_inputs();
      total_cnt++; if (bus.out_valid !== 1'b1 || bus.out_result !== 32'h55 || bus.out_dst !== 5'd4) $display("FAIL %s_next: got v=%b %h dst=%0d want v=1 00000055 dst=4", name, bus.out_valid, bus.out_result, bus.out_dst); else pass_cnt++;
      tick();
   endtask

   task automatic test_flush_wait();
      bus.out_ready = 1'b1;
      present(32'h4000, 32'd0, 3'd5, 2'd0, 1'b0, 5'd7);
      tick();
      clear_inputs();
      bus.data_addr_ok = 1'b1;
      tick();
      bus.data_addr_ok = 1'b0;
      bus.flush = 1'b1;
      total_cnt++; if (bus.in_ready !== 1'b0) $display("FAIL flush_in_ready: got %b want 0", bus.in_ready); else pass_cnt++;
      tick();
      bus.flush = 1'b0;
      present(32'h77, 32'd0, 3'd0, 2'd0, 1'b0, 5'd8);
      for (int c = 0; c < 2; c++) begin
         total_cnt++; if (dbg_state !== S_DRAIN || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0 || bus.data_req !== 1'b0) $display("FAIL drain%0d: got st=%0d v=%b rdy=%b req=%b want 4 0 0 0", c, dbg_state, bus.out_valid, bus.in_ready, bus.data_req); else pass_cnt++;
         tick();
      end
      bus.data_data_ok = 1'b1;
      bus.data_rdata   = 32'hCAFE_F00D;
      tick();
      bus.data_data_ok = 1'b0;
      total_cnt++; if (dbg_state !== S_IDLE || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) $display("FAIL drain_exit: got st=%0d v=%b rdy=%b want 0 0 1", dbg_state, bus.out_valid, bus.in_ready); else pass_cnt++;
      tick();
      clear_inputs();
      total_cnt++; if (bus.out_valid !== 1'b1 || bus.out_result !== 32'h77) $display("FAIL drain_after: got v=%b %h want v=1 00000077", bus.out_valid, bus.out_result); else pass_cnt++;
      tick();
   endtask

   task automatic test_flush_done();
      bus.out_ready = 1'b0;
      present(32'h99, 32'd0, 3'd0, 2'd0, 1'b0, 5'd2);
      tick();
      clear_inputs();
      bus.flush = 1'b1;
      total_cnt++; if (bus.out_valid !== 1'b1) $display("FAIL fdone_hold: got %b want 1", bus.out_valid); else pass_cnt++;
      tick();
      bus.flush = 1'b0;
      total_cnt++; if (bus.out_valid !== 1'b0 || dbg_state !== S_IDLE) $display("FAIL fdone_drop: got v=%b st=%0d want 0 0", bus.out_valid, dbg_state); else pass_cnt++;
      bus.out_ready = 1'b1;
   endtask

   task automatic test_except();
      bus.out_ready = 1'b1;
      present(32'h5001, 32'd0, 3'd5, 2'd0, 1'b1, 5'd6);
      tick();
      clear_inputs();
      total_cnt++; if (bus.data_req !== 1'b0 || bus.out_valid !== 1'b1 || bus.out_result !== 32'h5001) $display("FAIL except_out: got req=%b v=%b %h want 0 1 00005001", bus.data_req, bus.out_valid, bus.out_result); else pass_cnt++;
      tick();
      total_cnt++; if (bus.data_req !== 1'b0) $display("FAIL except_noreq: got %b want 0", bus.data_req); else pass_cnt++;
   endtask

   task automatic test_async_reset();
      bus.out_ready = 1'b1;
      present(32'h6000, 32'd0, 3'd5, 2'd0, 1'b0, 5'd1);
      tick();
      clear_inputs();
      total_cnt++; if (bus.data_req !== 1'b1 || dbg_state !== S_REQ) $display("FAIL areset_pre: got req=%b st=%0d want 1 1", bus.data_req, dbg_state); else pass_cnt++;
      #2 resetn = 1'b0;
      #1;
      total_cnt++; if (bus.data_req !== 1'b0 || bus.out_valid !== 1'b0 || dbg_state !== S_IDLE) $display("FAIL areset_now: got req=%b v=%b st=%0d want 0 0 0", bus.data_req, bus.out_valid, dbg_state); else pass_cnt++;
      @(posedge clk);
      #1 resetn = 1'b1;
      tick();
      total_cnt++; if (dbg_state !== S_IDLE || bus.in_ready !== 1'b1 || bus.data_req !== 1'b0) $display("FAIL areset_after: got st=%0d rdy=%b req=%b want 0 1 0", dbg_state, bus.in_ready, bus.data_req); else pass_cnt++;
   endtask

   initial begin
      pass_cnt  = 0;
      total_cnt = 0;
      test_reset();
      test_back_to_back();
      test_load("lb",  3'd1, 32'h1003, 32'h80FF_1234, 2'd0, 32'hFFFF_FF80);
      test_load("lbu", 3'd2, 32'h1003, 32'h80FF_1234, 2'd0, 32'h0000_0080);
      test_load("lh",  3'd3, 32'h1002, 32'h80FF_1234, 2'd1, 32'hFFFF_80FF);
      test_load("lhu", 3'd4, 32'h1000, 32'h80FF_9234, 2'd1, 32'h0000_9234);
      test_load("lw",  3'd5, 32'h1004, 32'h80FF_1234, 2'd2, 32'h80FF_1234);
      test_store("sh", 2'd2, 32'h2002, 32'hDEAD_BEEF, 32'hBEEF_BEEF, 4'b1100, 2'd1);
      test_store("sb", 2'd1, 32'h3001, 32'h1234_5678, 32'h7878_7878, 4'b0010, 2'd0);
      test_store("sw", 2'd3, 32'h3008, 32'h1234_5678, 32'h1234_5678, 4'b1111, 2'd2);
      test_flush_wait();
      test_flush_done();
      test_except();
      test_async_reset();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule
